// File: rtl/ps2_key_event_fifo.sv
// ps2_key_event_fifo: PS/2 receiver, E0/F0 prefix decoder and key event FIFO
module ps2_key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     rd_pop,
  output logic                     valid,
  output logic [7:0]               key_code,
  output logic                     key_down,
  output logic                     key_ext,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     frame_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  logic [2:0] c_sync, d_sync;
  logic [3:0] bit_cnt;
  logic [9:0] sr;
  logic [IW-1:0] idle;
  logic [7:0] rx_byte;
  logic rx_valid;
  state_t state;
  logic [9:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic fall, bit_in, frame_ok, is_e0, is_f0, in_ext, in_brk, emit, full, pop, push, drop;
  logic [9:0] ev, head;
  assign fall = c_sync[2:1] == 2'b10;
  assign bit_in = d_sync[2];
  // sr holds start in [0], data in [8:1], parity in [9]; bit_in is the stop bit
  assign frame_ok = !sr[0] && bit_in && (^sr[9:1]);
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      c_sync <= '1;
      d_sync <= '1;
      bit_cnt <= '0;
      sr <= '0;
      idle <= '0;
      rx_byte <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      c_sync <= {c_sync[1:0], ps2_clk};
      d_sync <= {d_sync[1:0], ps2_data};
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        idle <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          rx_valid <= frame_ok;
          frame_err <= !frame_ok;
          if (frame_ok) rx_byte <= sr[8:1];
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          sr <= {bit_in, sr[9:1]};
        end
      end else begin
        if (idle != IW'(TIMEOUT_CYCLES)) idle <= idle + 1'b1;
        if (bit_cnt != 4'd0 && idle == IW'(TIMEOUT_CYCLES)) bit_cnt <= '0;
      end
    end
  end
  assign is_e0 = rx_byte == 8'hE0;
  assign is_f0 = rx_byte == 8'hF0;
  assign in_ext = state == EXT || state == EXT_BRK;
  assign in_brk = state == BRK || state == EXT_BRK;
  assign emit = rx_valid && !is_e0 && !is_f0;
  assign ev = {in_ext, !in_brk, rx_byte};
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else if (rx_valid) state <= is_e0 ? EXT : is_f0 ? (in_ext ? EXT_BRK : BRK) : IDLE;
  end
  assign valid = count != '0;
  assign full = count == CW'(DEPTH);
  assign pop = rd_pop && valid;
  // a pop in the same cycle frees the slot the push needs
  assign push = emit && (!full || pop);
  assign drop = emit && full && !pop;
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= ev;
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      overflow <= drop ? 1'b1 : pop ? 1'b0 : overflow;
    end
  end
  assign head = mem[rptr];
  assign key_code = valid ? head[7:0] : 8'h00;
  assign key_down = valid && head[8];
  assign key_ext = valid && head[9];
endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// tb_ps2_key_event_fifo: directed PS/2 frames checked against a queue-based event model
module tb_ps2_key_event_fifo;
  localparam int DEPTH = 8;
  localparam int TMO = 200;
  localparam int H = 10;
  logic clk = 0, clrn = 1, ps2_clk = 1, ps2_data = 1, rd_pop = 0;
  logic valid, key_down, key_ext, overflow, frame_err;
  logic [7:0] key_code;
  logic [3:0] count;
  int checks = 0, errors = 0;
  logic [9:0] q[$];
  bit m_ext = 0, m_brk = 0, m_ovf = 0, m_ferr = 0, run = 0;

  ps2_key_event_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_pop(rd_pop),
    .valid(valid), .key_code(key_code), .key_down(key_down), .key_ext(key_ext),
    .count(count), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("valid", 32'(valid), 32'(q.size() != 0));
      chk("key_code", 32'(key_code), q.size() != 0 ? 32'(q[0][7:0]) : 32'h0);
      chk("key_down", 32'(key_down), q.size() != 0 ? 32'(q[0][8]) : 32'h0);
      chk("key_ext", 32'(key_ext), q.size() != 0 ? 32'(q[0][9]) : 32'h0);
      chk("count", 32'(count), 32'(q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_step(input logic [7:0] b, input bit has_byte, input bit do_pop);
    if (do_pop && q.size() != 0) begin
      void'(q.pop_front());
      m_ovf = 0;
    end
    if (has_byte) begin
      if (b == 8'hE0) begin
        m_ext = 1;
        m_brk = 0;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else begin
        if (q.size() < DEPTH) q.push_back({m_ext, !m_brk, b});
        else m_ovf = 1;
        m_ext = 0;
        m_brk = 0;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input bit pop_push);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = f[i];
      step(H);
      ps2_clk = 0;
      if (i == 10) begin
        step(3);
        m_ferr = bad;
        if (pop_push) rd_pop = 1;
        step(1);
        m_ferr = 0;
        rd_pop = 0;
        model_step(b, !bad, pop_push);
        step(H - 4);
      end else begin
        step(H);
      end
      ps2_clk = 1;
    end
    ps2_data = 1;
    step(H);
  endtask

  task automatic send_partial(input int n);
    logic [10:0] f;
    f = {1'b1, 1'b0, 8'h1C, 1'b0};
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      step(H);
      ps2_clk = 0;
      step(H);
      ps2_clk = 1;
    end
    ps2_data = 1;
    step(H);
  endtask

  task automatic pop1();
    rd_pop = 1;
    step(1);
    rd_pop = 0;
    model_step(8'h00, 0, 1);
    step(2);
  endtask

  task automatic chk_head(input string n, input logic [7:0] c, input bit d, input bit x);
    chk({n, "_code"}, 32'(key_code), 32'(c));
    chk({n, "_down"}, 32'(key_down), 32'(d));
    chk({n, "_ext"}, 32'(key_ext), 32'(x));
  endtask

  initial begin
    #2 clrn = 0;
    run = 1;
    step(3);
    clrn = 1;
    step(5);
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_code", 32'(key_code), 32'h0);
    send_frame(8'h1C, 0, 0);
    chk_head("make", 8'h1C, 1, 0);
    chk("make_count", 32'(count), 32'd1);
    pop1();
    chk("pop_valid", 32'(valid), 32'h0);
    chk("pop_code", 32'(key_code), 32'h0);
    send_frame(8'hF0, 0, 0);
    chk("prefix_silent", 32'(count), 32'h0);
    send_frame(8'h1C, 0, 0);
    chk_head("brk", 8'h1C, 0, 0);
    pop1();
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    chk("ext_count", 32'(count), 32'd2);
    chk_head("ext_make", 8'h75, 1, 1);
    pop1();
    chk_head("ext_brk", 8'h75, 0, 1);
    pop1();
    send_frame(8'hF0, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h1C, 0, 0);
    chk_head("e0_clears_brk", 8'h1C, 1, 1);
    pop1();
    send_frame(8'h1C, 1, 0);
    chk("bad_par_count", 32'(count), 32'h0);
    send_frame(8'h1B, 0, 0);
    chk_head("after_err", 8'h1B, 1, 0);
    pop1();
    for (int i = 0; i < 9; i++) send_frame(8'(8'h15 + i), 0, 0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk_head("full_head", 8'h15, 1, 0);
    send_frame(8'h1E, 0, 1);
    chk("pp_count", 32'(count), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk_head("pp_head", 8'h16, 1, 0);
    repeat (8) pop1();
    pop1();
    chk("empty_pop_count", 32'(count), 32'h0);
    send_partial(5);
    step(TMO + 100);
    send_frame(8'h1C, 0, 0);
    chk_head("after_timeout", 8'h1C, 1, 0);
    pop1();
    send_frame(8'h1D, 0, 0);
    send_partial(5);
    clrn = 0;
    q.delete();
    m_ext = 0;
    m_brk = 0;
    m_ovf = 0;
    step(2);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk_head("rst_head", 8'h00, 0, 0);
    clrn = 1;
    step(5);
    send_frame(8'h1C, 0, 0);
    chk_head("after_rst", 8'h1C, 1, 0);
    chk("after_rst_count", 32'(count), 32'd1);
    pop1();
    step(5);
    run = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
